// File: rtl/display_scan_if.sv
// Display scan controller bus: snapshot inputs and decoder-facing outputs.
interface display_scan_if;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [7:0] result;
  logic       show_result;
  logic       load;
  logic [3:0] digit_idx;
  logic [3:0] nibble;
  logic       position;
  logic       frame_done;

  modport master (
    output operand_a, operand_b, result, show_result, load,
    input  digit_idx, nibble, position, frame_done
  );

  modport slave (
    input  operand_a, operand_b, result, show_result, load,
    output digit_idx, nibble, position, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: walks the lit digits of the committed mode,
// dwelling DWELL cycles on each, and shows tear-free operand/result snapshots.
module display_scan_ctrl #(
  parameter int DWELL = 100_000,
  parameter int CNT_W = 17
) (
  input logic           clk,
  input logic           reset,
  display_scan_if.slave bus
);

  typedef enum logic [2:0] {SL0, SL1, SL4, SL5, SL6, SL7} slot_t;

  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q;
  logic             adv, bnd;
  logic [7:0]       act_a, act_b, act_r;
  logic [7:0]       pnd_a, pnd_b, pnd_r;
  logic [7:0]       nxt_a, nxt_b, nxt_r;
  logic             pnd_vld;
  logic [3:0]       dig_d, nib_d;
  logic [3:0]       dig_q, nib_q;
  logic             pos_q, fd_q;

  // Slot advances when the dwell count expires; a frame wraps out of slot 5 or 7.
  assign adv = (cnt_q == CNT_W'(DWELL - 1));
  assign bnd = adv && (slot_q == SL5 || slot_q == SL7);

  // Slot state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) slot_q <= SL0;
    else        slot_q <= slot_d;
  end

  // Next slot; the mode request is only honoured at the frame wrap.
  always_comb begin
    slot_d = slot_q;
    if (adv) begin
      case (slot_q)
        SL0:     slot_d = SL1;
        SL1:     slot_d = SL4;
        SL4:     slot_d = SL5;
        SL6:     slot_d = SL7;
        default: slot_d = bus.show_result ? SL6 : SL0;
      endcase
    end
  end

  // Dwell counter, 0..DWELL-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt_q <= '0;
    else if (adv) cnt_q <= '0;
    else          cnt_q <= cnt_q + 1'b1;
  end

  // Active snapshot for the next cycle: a load in the wrap cycle beats pending.
  always_comb begin
    nxt_a = act_a;
    nxt_b = act_b;
    nxt_r = act_r;
    if (bnd && bus.load) begin
      nxt_a = bus.operand_a;
      nxt_b = bus.operand_b;
      nxt_r = bus.result;
    end else if (bnd && pnd_vld) begin
      nxt_a = pnd_a;
      nxt_b = pnd_b;
      nxt_r = pnd_r;
    end
  end

  // Active and pending snapshots; the last load before the wrap wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {act_a, act_b, act_r} <= '0;
      {pnd_a, pnd_b, pnd_r} <= '0;
      pnd_vld               <= 1'b0;
    end else begin
      {act_a, act_b, act_r} <= {nxt_a, nxt_b, nxt_r};
      if (bus.load && !bnd) begin
        {pnd_a, pnd_b, pnd_r} <= {bus.operand_a, bus.operand_b, bus.result};
        pnd_vld               <= 1'b1;
      end else if (bnd) begin
        pnd_vld <= 1'b0;
      end
    end
  end

  // Digit index and nibble of the slot being entered, from the next snapshot.
  always_comb begin
    dig_d = 4'd0;
    nib_d = nxt_a[7:4];
    case (slot_d)
      SL1:     begin dig_d = 4'd1; nib_d = nxt_a[3:0]; end
      SL4:     begin dig_d = 4'd4; nib_d = nxt_b[7:4]; end
      SL5:     begin dig_d = 4'd5; nib_d = nxt_b[3:0]; end
      SL6:     begin dig_d = 4'd6; nib_d = nxt_r[7:4]; end
      SL7:     begin dig_d = 4'd7; nib_d = nxt_r[3:0]; end
      default: begin dig_d = 4'd0; nib_d = nxt_a[7:4]; end
    endcase
  end

  // Registered outputs, updated together on each slot advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_q <= 4'd0;
      nib_q <= 4'd0;
      pos_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= bnd;
      if (adv) begin
        dig_q <= dig_d;
        nib_q <= nib_d;
        pos_q <= bnd ? bus.show_result : pos_q;
      end
    end
  end

  assign bus.digit_idx  = dig_q;
  assign bus.nibble     = nib_q;
  assign bus.position   = pos_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed vector table, hand-written corner
// sequences and random traffic against a frame-level reference model.
module tb_display_scan_ctrl;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  display_scan_if bus();

  display_scan_ctrl #(.DWELL(DWELL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: lit-digit lists per mode, frame index, byte snapshots.
  int         seq0[4] = '{0, 1, 4, 5};
  int         m_cnt, m_pos, m_idx;
  logic [7:0] m_act[3];
  logic [7:0] m_pnd[3];
  bit         m_pv;
  logic [3:0] e_dig, e_nib;
  bit         e_pos, e_fd;

  function automatic int digit_of(int pos, int idx);
    return pos ? 6 + idx : seq0[idx];
  endfunction

  function automatic logic [3:0] nib_of(int d);
    logic [7:0] v;
    v = (d < 2) ? m_act[0] : ((d < 6) ? m_act[1] : m_act[2]);
    return (d % 2 == 0) ? v[7:4] : v[3:0];
  endfunction

  function automatic void m_rst();
    m_cnt = 0; m_pos = 0; m_idx = 0; m_pv = 0;
    for (int i = 0; i < 3; i++) begin m_act[i] = 8'h0; m_pnd[i] = 8'h0; end
    e_dig = 0; e_nib = 0; e_pos = 0; e_fd = 0;
  endfunction

  function automatic bit m_wrap_next();
    return (m_cnt == DWELL - 1) && (m_idx == (m_pos ? 1 : 3));
  endfunction

  // One clock of the model, using the inputs present before the edge.
  function automatic void m_step();
    bit bnd;
    bnd  = m_wrap_next();
    e_fd = 0;
    if (m_cnt == DWELL - 1) begin
      m_cnt = 0;
      if (bnd) begin
        e_fd  = 1;
        m_pos = int'(bus.show_result);
        m_idx = 0;
        if (bus.load) begin
          m_act[0] = bus.operand_a; m_act[1] = bus.operand_b; m_act[2] = bus.result;
        end else if (m_pv) begin
          m_act = m_pnd;
        end
        m_pv = 0;
      end else begin
        m_idx++;
      end
      e_dig = 4'(digit_of(m_pos, m_idx));
      e_nib = nib_of(int'(e_dig));
      e_pos = m_pos[0];
    end else begin
      m_cnt++;
    end
    if (bus.load && !bnd) begin
      m_pnd[0] = bus.operand_a; m_pnd[1] = bus.operand_b; m_pnd[2] = bus.result;
      m_pv = 1;
    end
  endfunction

  function automatic logic [9:0] dut_out();
    return {bus.digit_idx, bus.nibble, bus.position, bus.frame_done};
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("model", 32'(dut_out()), 32'({e_dig, e_nib, e_pos, e_fd}));
  endtask

  // Tick until digit d has just been entered.
  task automatic wait_for(input int d, input int lim);
    int n = 0;
    do begin tick(); n++; end while (!(e_dig == d && m_cnt == 0) && n < lim);
    chk($sformatf("reach_digit%0d", d), 32'(e_dig == d && m_cnt == 0), 32'd1);
  endtask

  typedef struct {
    bit         load, show;
    logic [7:0] a, b, r;
    logic [3:0] dig, nib;
    bit         pos, fd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_run(int n, bit ld, bit sh, logic [3:0] d, logic [3:0] nb, bit p, bit fd);
    for (int i = 0; i < n; i++)
      tbl.push_back('{ld && i == 0, sh, 8'h3C, 8'hA5, 8'h00, d, nb, p, fd && i == 0});
  endfunction

  initial begin
    int n;
    m_rst();
    bus.operand_a = 0; bus.operand_b = 0; bus.result = 0;
    bus.show_result = 0; bus.load = 0;

    // Basic scan, load visibility after one frame, then mode switch mid-frame.
    add_run(3, 1, 0, 4'd0, 4'h0, 0, 0);
    add_run(4, 0, 0, 4'd1, 4'h0, 0, 0);
    add_run(4, 0, 0, 4'd4, 4'h0, 0, 0);
    add_run(4, 0, 0, 4'd5, 4'h0, 0, 0);
    add_run(4, 0, 0, 4'd0, 4'h3, 0, 1);
    add_run(4, 0, 0, 4'd1, 4'hC, 0, 0);
    add_run(4, 0, 0, 4'd4, 4'hA, 0, 0);
    add_run(4, 0, 0, 4'd5, 4'h5, 0, 0);
    add_run(4, 0, 0, 4'd0, 4'h3, 0, 1);
    add_run(4, 0, 1, 4'd1, 4'hC, 0, 0);
    add_run(4, 0, 1, 4'd4, 4'hA, 0, 0);
    add_run(4, 0, 1, 4'd5, 4'h5, 0, 0);
    add_run(4, 0, 1, 4'd6, 4'h0, 1, 1);
    add_run(4, 0, 1, 4'd7, 4'h0, 1, 0);
    add_run(4, 0, 1, 4'd6, 4'h0, 1, 1);
    add_run(4, 0, 1, 4'd7, 4'h0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(dut_out()), 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      bus.load = tbl[i].load; bus.show_result = tbl[i].show;
      bus.operand_a = tbl[i].a; bus.operand_b = tbl[i].b; bus.result = tbl[i].r;
      tick();
      chk($sformatf("vec%0d", i), 32'(dut_out()),
          32'({tbl[i].dig, tbl[i].nib, tbl[i].pos, tbl[i].fd}));
    end
    bus.load = 0;

    // Load during digit 6 does not tear the current frame.
    bus.result = 8'h7E; bus.load = 1; tick(); bus.load = 0;
    wait_for(6, 20); wait_for(6, 20);
    bus.result = 8'h42; bus.load = 1; tick(); bus.load = 0;
    wait_for(7, 20); chk("tear_free_E", 32'(bus.nibble), 32'hE);
    wait_for(6, 20); chk("new_hi_4", 32'(bus.nibble), 32'h4);
    wait_for(7, 20); chk("new_lo_2", 32'(bus.nibble), 32'h2);

    // Two loads in one frame: last wins.
    bus.result = 8'h11; bus.load = 1; tick(); bus.load = 0; tick();
    bus.result = 8'h99; bus.load = 1; tick(); bus.load = 0;
    wait_for(6, 20); chk("last_load_hi", 32'(bus.nibble), 32'h9);
    wait_for(7, 20); chk("last_load_lo", 32'(bus.nibble), 32'h9);

    // Load in the exact wrap cycle goes straight to the display.
    n = 0;
    while (!m_wrap_next() && n < 20) begin tick(); n++; end
    chk("found_wrap", 32'(m_wrap_next()), 32'd1);
    bus.result = 8'h5F; bus.load = 1; tick(); bus.load = 0;
    chk("wrap_load_hi", 32'({bus.digit_idx, bus.nibble, bus.frame_done}), 32'({4'd6, 4'h5, 1'b1}));
    chk("wrap_pend_clear", 32'(dut.pnd_vld), 32'd0);
    wait_for(7, 20); chk("wrap_load_lo", 32'(bus.nibble), 32'hF);

    // Async reset mid-dwell with a pending load discards everything.
    bus.show_result = 0;
    wait_for(0, 40); wait_for(5, 40);
    bus.operand_a = 8'h12; bus.operand_b = 8'h34; bus.result = 8'h56;
    bus.load = 1; tick(); bus.load = 0;
    #2 reset = 1'b0;
    #1 chk("async_reset_out", 32'(dut_out()), 32'd0);
    m_rst();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("post_reset_zero", 32'(bus.nibble), 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.operand_a = 8'($urandom); bus.operand_b = 8'($urandom); bus.result = 8'($urandom);
      bus.load = ($urandom % 6) == 0;
      if (($urandom % 20) == 0) bus.show_result = ~bus.show_result;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
